dec3_8_stretch: RTL and testbench

- Decoder end of the 8-to-3 priority-encoder interface: takes a strobed 3-bit code plus valid flag (the encoder's O/s pair) and drives a one-hot 8-bit output.
- Each decoded line is pulse-stretched by its own hold counter, so single-cycle codes stay visible long enough for LEDs or segment enables on the board.
- Also re-encodes the currently lit lines (highest index wins) so a bench can loop encoder→decoder→encoder.

---
 rtl/dec3_8_stretch.sv | 126 ++++++++++++
 tb/tb_dec3_8_stretch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dec3_8_stretch.sv
// dec3_8_stretch: strobed 3:8 decoder with a per-line pulse stretcher.
//   Each accepted code loads its line's hold counter with HOLD_CYCLES. The line
//   stays lit while its counter is non-zero. The lit set is re-encoded so that
//   the highest lit index is reported on out_code.
//   Build option DEC_EXCL_EN selects exclusive mode: an accept clears every
//   other line, so at most one line is ever lit.
//   The default build (DEC_EXCL_EN undefined) lets lines overlap.

// One decoded line: a hold counter that can be reloaded, cleared, or left to
// count down to zero.
module dec3_8_line #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    output logic lit
);
    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: reload beats clear beats decrement; zero holds at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = HOLD;
        else if (clear)
            cnt_d = '0;
        else if (cnt_q != '0)
            cnt_d = cnt_q - ONE;
    end

    // Counter register; reset drops the line immediately.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign lit = (cnt_q != '0);
endmodule

module dec3_8_stretch #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    output logic       in_ready,
    output logic [7:0] out_onehot,
    output logic       out_any,
    output logic [2:0] out_code,
    output logic [7:0] out_hits
);
    localparam int NUM_LINES = 8;

    // A hold time that does not fit the counter would silently truncate.
    if (HOLD_CYCLES < 1 || HOLD_CYCLES >= (1 << CNT_W)) begin : g_bad_hold
        $error("dec3_8_stretch: HOLD_CYCLES must be in 1..2**CNT_W-1");
    end

    logic                 ready_q, ready_d;
    logic [7:0]           hits_q, hits_d;
    logic                 accept;
    logic [NUM_LINES-1:0] load, clear, lit;
    logic [2:0]           code_d;

    assign accept = in_valid & ready_q;

    // Ready rises one edge after reset is released and then stays up.
    // The hit counter advances on each accepted strobe and wraps at 256.
    always_comb begin
        ready_d = 1'b1;
        hits_d  = hits_q + {7'd0, accept};
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            hits_q  <= 8'h00;
        end else begin
            ready_q <= ready_d;
            hits_q  <= hits_d;
        end
    end

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        assign load[i] = accept & (in_code == 3'(i));
`ifdef DEC_EXCL_EN
        assign clear[i] = accept & (in_code != 3'(i));
`else
        assign clear[i] = 1'b0;
`endif
        dec3_8_line #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .CNT_W       (CNT_W)
        ) u_line (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .clear (clear[i]),
            .lit   (lit[i])
        );
    end

    // Priority-encode the lit lines; the highest index wins, and none lit gives 0.
    always_comb begin
        code_d = 3'd0;
        for (int i = 0; i < NUM_LINES; i++)
            if (lit[i]) code_d = 3'(i);
    end

    assign in_ready   = ready_q;
    assign out_onehot = lit;
    assign out_any    = |lit;
    assign out_code   = code_d;
    assign out_hits   = hits_q;
endmodule

// File: tb/tb_dec3_8_stretch.sv
// Testbench for dec3_8_stretch: directed scenarios plus a randomized run
// against a deadline-based reference model (HOLD_CYCLES = 4).
module tb_dec3_8_stretch;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = 3'd0;
    logic       in_ready, out_any;
    logic [7:0] out_onehot, out_hits;
    logic [2:0] out_code;

    dec3_8_stretch #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_any    (out_any),
        .out_code   (out_code),
        .out_hits   (out_hits)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: a line is lit after edge n while n < lit_until[line].
    int edge_n = 0;
    int lit_until[8];
    int m_hits = 0;
    bit m_ready = 0;

    function automatic logic [7:0] exp_oh();
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) if (edge_n < lit_until[i]) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [2:0] exp_code();
        logic [7:0] r = exp_oh();
        logic [2:0] c = 3'd0;
        for (int i = 0; i < 8; i++) if (r[i]) c = 3'(i);
        return c;
    endfunction

    // Drive one cycle from a negedge, update the model at the edge, and return at the next negedge.
    task automatic step(input bit rst, input bit v, input logic [2:0] c);
        rst_n = rst; in_valid = v; in_code = c;
        @(posedge clk);
        edge_n++;
        if (!rst) begin
            for (int i = 0; i < 8; i++) lit_until[i] = 0;
            m_hits = 0;
            m_ready = 0;
        end else begin
            if (v && m_ready) begin
`ifdef DEC_EXCL_EN
                for (int j = 0; j < 8; j++) lit_until[j] = 0;
`endif
                lit_until[c] = edge_n + H;
                m_hits = (m_hits + 1) % 256;
            end
            m_ready = 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
    endtask

    task automatic test_reset();
        step(0, 1, 3);
        step(0, 1, 3);
        n_checks++;
        if (out_onehot !== 8'h00 || out_code !== 3'd0 || out_any !== 1'b0 ||
            out_hits !== 8'h00 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got oh=%h code=%0d any=%b hits=%0d rdy=%b, want 00/0/0/0/0",
                     out_onehot, out_code, out_any, out_hits, in_ready);
        end
        step(1, 0, 0);
        n_checks++;
        if (in_ready !== 1'b1 || out_onehot !== 8'h00 || out_hits !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b oh=%h hits=%0d, want 1/00/0",
                     in_ready, out_onehot, out_hits);
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int s = 0; s <= H; s++) begin
            step(1, s == 0, 3'd5);
            n_checks++;
            if (s < H) begin
                if (out_onehot !== 8'h20 || out_code !== 3'd5 || out_any !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_lit s=%0d: got oh=%h code=%0d any=%b, want 20/5/1",
                             s, out_onehot, out_code, out_any);
                end
            end else if (out_onehot !== 8'h00 || out_code !== 3'd0 || out_any !== 1'b0) begin
                n_fail++;
                $display("FAIL single_off: got oh=%h code=%0d any=%b, want 00/0/0",
                         out_onehot, out_code, out_any);
            end
        end
        n_checks++;
        if (out_hits !== 8'd1) begin
            n_fail++;
            $display("FAIL single_hits: got %0d want 1", out_hits);
        end
    endtask

    task automatic test_overlap();
`ifdef DEC_EXCL_EN
        logic [7:0] t_oh[7] = '{8'h02, 8'h02, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00};
`else
        logic [7:0] t_oh[7] = '{8'h02, 8'h02, 8'h42, 8'h42, 8'h40, 8'h40, 8'h00};
`endif
        logic [2:0] t_code[7] = '{3'd1, 3'd1, 3'd6, 3'd6, 3'd6, 3'd6, 3'd0};
        do_reset();
        for (int s = 0; s < 7; s++) begin
            step(1, (s == 0) || (s == 2), (s == 0) ? 3'd1 : 3'd6);
            n_checks++;
            if (out_onehot !== t_oh[s] || out_code !== t_code[s]) begin
                n_fail++;
                $display("FAIL overlap s=%0d: got oh=%h code=%0d, want %h/%0d",
                         s, out_onehot, out_code, t_oh[s], t_code[s]);
            end
        end
        n_checks++;
        if (out_hits !== 8'd2) begin
            n_fail++;
            $display("FAIL overlap_hits: got %0d want 2", out_hits);
        end
    endtask

    // Strobes at s=0,3,6,9 keep bit 3 lit through s=12.
    task automatic test_reload();
        do_reset();
        for (int s = 0; s < 14; s++) begin
            step(1, (s % 3 == 0) && (s <= 9), 3'd3);
            n_checks++;
            if (out_onehot !== ((s <= 12) ? 8'h08 : 8'h00)) begin
                n_fail++;
                $display("FAIL reload s=%0d: got oh=%h want %h",
                         s, out_onehot, (s <= 12) ? 8'h08 : 8'h00);
            end
        end
        n_checks++;
        if (out_hits !== 8'd4) begin
            n_fail++;
            $display("FAIL reload_hits: got %0d want 4", out_hits);
        end
    endtask

    // A re-strobe in the final lit cycle extends the line with no gap.
    task automatic test_final_cycle();
        do_reset();
        for (int s = 0; s < 9; s++) begin
            step(1, (s == 0) || (s == H), 3'd0);
            n_checks++;
            if (out_onehot !== ((s < 2 * H) ? 8'h01 : 8'h00)) begin
                n_fail++;
                $display("FAIL final_cycle s=%0d: got oh=%h want %h",
                         s, out_onehot, (s < 2 * H) ? 8'h01 : 8'h00);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 1, 3'd7);
        step(1, 0, 3'd0);
        step(0, 1, 3'd2);
        n_checks++;
        if (out_onehot !== 8'h00 || out_hits !== 8'h00 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got oh=%h hits=%0d rdy=%b, want 00/0/0",
                     out_onehot, out_hits, in_ready);
        end
        step(0, 1, 3'd4);
        step(1, 0, 3'd0);
        n_checks++;
        if (out_onehot !== 8'h00 || out_hits !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_after: got oh=%h hits=%0d rdy=%b, want 00/0/1",
                     out_onehot, out_hits, in_ready);
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 1, 3'd2);
        n_checks++;
        if (out_hits !== 8'h00 || out_onehot !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_not_ready: got hits=%0d oh=%h, want 0/00", out_hits, out_onehot);
        end
        for (int n = 1; n <= 256; n++) begin
            step(1, 1, 3'($urandom_range(0, 7)));
            if (n == 255) begin
                n_checks++;
                if (out_hits !== 8'hff) begin
                    n_fail++;
                    $display("FAIL wrap_255: got %0d want 255", out_hits);
                end
            end
        end
        n_checks++;
        if (out_hits !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_256: got %0d want 0", out_hits);
        end
    endtask

    task automatic test_random();
        logic [7:0] eo;
        do_reset();
        for (int s = 0; s < 400; s++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 7)));
            eo = exp_oh();
            n_checks++;
            if (out_onehot !== eo || out_code !== exp_code() || out_any !== (eo != 8'h00) ||
                out_hits !== 8'(m_hits) || in_ready !== m_ready) begin
                n_fail++;
                $display("FAIL random s=%0d: got oh=%h code=%0d any=%b hits=%0d rdy=%b, want %h/%0d/%b/%0d/%b",
                         s, out_onehot, out_code, out_any, out_hits, in_ready,
                         eo, exp_code(), eo != 8'h00, m_hits, m_ready);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) lit_until[i] = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_overlap();
        test_reload();
        test_final_cycle();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
